// File: rtl/ex_fwd_scoreboard.sv
// EX-stage operand forwarding, load-use / long-latency hazard detection and
// register scoreboard with saturating stall counters.
module ex_fwd_scoreboard #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int NUM_RD = 2,
    parameter int LU_MAX = 2,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid_i,
    input  logic [NUM_RD*REG_AW-1:0] id_rs_addr_i,
    input  logic [NUM_RD-1:0]        id_rs_used_i,
    input  logic [REG_AW-1:0]        id_rd_addr_i,
    input  logic                     id_reg_w_ena_i,
    input  logic                     id_mem_w_ena_i,
    input  logic                     id_long_op_i,
    input  logic                     flush_i,
    input  logic [NUM_RD*REG_AW-1:0] ex_rs_addr_i,
    input  logic [NUM_RD*XLEN-1:0]   ex_rs_data_i,
    input  logic [REG_AW-1:0]        ex_rd_addr_i,
    input  logic                     ex_reg_w_ena_i,
    input  logic                     ex_mem_r_ena_i,
    input  logic                     ex_mem_w_ena_i,
    input  logic [REG_AW-1:0]        mem_rd_addr_i,
    input  logic                     mem_reg_w_ena_i,
    input  logic                     mem_mem_r_ena_i,
    input  logic [XLEN-1:0]          mem_reg_w_data_i,
    input  logic [REG_AW-1:0]        wb_rd_addr_i,
    input  logic                     wb_reg_w_ena_i,
    input  logic [XLEN-1:0]          wb_reg_w_data_i,
    input  logic                     lu_done_i,
    input  logic [REG_AW-1:0]        lu_done_rd_i,
    input  logic                     lu_kill_i,
    input  logic                     cnt_clr_i,
    output logic [NUM_RD*XLEN-1:0]   ex_op_data_o,
    output logic [2*NUM_RD-1:0]      fwd_sel_o,
    output logic                     fwd_c_o,
    output logic                     hazard_hold_o,
    output logic [(2**REG_AW)-1:0]   busy_o,
    output logic [2:0]               lu_cnt_o,
    output logic                     lu_err_o,
    output logic [CNT_W-1:0]         stall_load_cnt_o,
    output logic [CNT_W-1:0]         stall_lu_cnt_o
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic [2:0]        r_lu_cnt;
    logic [2:0]        w_lu_cnt_nxt;
    logic              r_lu_err;
    logic [CNT_W-1:0]  r_stall_load_cnt;
    logic [CNT_W-1:0]  r_stall_lu_cnt;

    logic [NUM_RD-1:0] w_ld_hit;
    logic [NUM_RD-1:0] w_raw_hit;
    logic              w_load_use;
    logic              w_lu_raw;
    logic              w_lu_waw;
    logic              w_lu_struct;
    logic              w_lu_hz;
    logic              w_hold;
    logic              w_issue;
    logic              w_done_hit;

    genvar g;
    for (g = 0; g < NUM_RD; g++) begin : g_op
        logic [REG_AW-1:0] w_rs;
        logic [REG_AW-1:0] w_id_rs;
        logic [1:0]        w_sel;

        assign w_rs    = ex_rs_addr_i[g*REG_AW +: REG_AW];
        assign w_id_rs = id_rs_addr_i[g*REG_AW +: REG_AW];

        // A load in EX/MEM has no data yet, so only ALU results forward from there.
        always_comb begin
            w_sel = 2'b00;
            if (w_rs != '0) begin
                if (mem_reg_w_ena_i && !mem_mem_r_ena_i && (mem_rd_addr_i == w_rs))
                    w_sel = 2'b10;
                else if (wb_reg_w_ena_i && (wb_rd_addr_i == w_rs))
                    w_sel = 2'b01;
            end
        end

        assign fwd_sel_o[2*g +: 2] = w_sel;
        assign ex_op_data_o[g*XLEN +: XLEN] =
            (w_sel == 2'b10) ? mem_reg_w_data_i :
            (w_sel == 2'b01) ? wb_reg_w_data_i  :
                               ex_rs_data_i[g*XLEN +: XLEN];

        // Store data (operand 1 of a store) is picked up by the MEM-stage forward instead.
        assign w_ld_hit[g]  = id_rs_used_i[g] && (w_id_rs == ex_rd_addr_i)
                              && !(id_mem_w_ena_i && (g == 1));
        assign w_raw_hit[g] = id_rs_used_i[g] && (w_id_rs != '0) && r_busy[w_id_rs];
    end

    assign fwd_c_o = ex_mem_w_ena_i && mem_mem_r_ena_i && mem_reg_w_ena_i
                     && (mem_rd_addr_i != '0)
                     && (mem_rd_addr_i == ex_rs_addr_i[REG_AW +: REG_AW]);

    assign w_load_use  = ex_mem_r_ena_i && ex_reg_w_ena_i && (ex_rd_addr_i != '0) && (|w_ld_hit);
    assign w_lu_raw    = |w_raw_hit;
    assign w_lu_waw    = id_reg_w_ena_i && r_busy[id_rd_addr_i];
    assign w_lu_struct = id_long_op_i && (r_lu_cnt == 3'(LU_MAX));
    assign w_lu_hz     = w_lu_raw || w_lu_waw || w_lu_struct;
    assign w_hold      = id_valid_i && !flush_i && (w_load_use || w_lu_hz);
    assign w_issue     = id_valid_i && id_long_op_i && !flush_i && !w_hold;
    assign w_done_hit  = lu_done_i && r_busy[lu_done_rd_i];

    // Set after clear so an issue and a retire on the same rd leave the bit owned by the new op.
    always_comb begin
        w_busy_nxt   = r_busy;
        w_lu_cnt_nxt = r_lu_cnt;
        if (lu_kill_i) begin
            w_busy_nxt   = '0;
            w_lu_cnt_nxt = '0;
        end else begin
            if (w_done_hit)
                w_busy_nxt[lu_done_rd_i] = 1'b0;
            if (w_issue && (id_rd_addr_i != '0))
                w_busy_nxt[id_rd_addr_i] = 1'b1;
            case ({w_issue, w_done_hit})
                2'b10:   w_lu_cnt_nxt = r_lu_cnt + 3'd1;
                2'b01:   w_lu_cnt_nxt = r_lu_cnt - 3'd1;
                default: w_lu_cnt_nxt = r_lu_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy           <= '0;
            r_lu_cnt         <= '0;
            r_lu_err         <= 1'b0;
            r_stall_load_cnt <= '0;
            r_stall_lu_cnt   <= '0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
            if (lu_done_i && !r_busy[lu_done_rd_i])
                r_lu_err <= 1'b1;
            if (cnt_clr_i) begin
                r_stall_load_cnt <= '0;
                r_stall_lu_cnt   <= '0;
            end else begin
                if (w_hold && w_load_use && !(&r_stall_load_cnt))
                    r_stall_load_cnt <= r_stall_load_cnt + CNT_W'(1);
                if (w_hold && w_lu_hz && !(&r_stall_lu_cnt))
                    r_stall_lu_cnt <= r_stall_lu_cnt + CNT_W'(1);
            end
        end
    end

    assign hazard_hold_o    = w_hold;
    assign busy_o           = r_busy;
    assign lu_cnt_o         = r_lu_cnt;
    assign lu_err_o         = r_lu_err;
    assign stall_load_cnt_o = r_stall_load_cnt;
    assign stall_lu_cnt_o   = r_stall_lu_cnt;

endmodule

// File: tb/tb_ex_fwd_scoreboard.sv
// Bench for ex_fwd_scoreboard: forwarding vector table, hand-written hazard
// sequences and randomized traffic against a behavioural scoreboard model.
module tb_ex_fwd_scoreboard;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NUM_RD = 2;
    localparam int LU_MAX = 2;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_reg_w, id_mem_w, id_long, flush;
    logic [4:0]  id_rs [2];
    logic [1:0]  id_used;
    logic [4:0]  id_rd;
    logic [4:0]  ex_rs [2];
    logic [31:0] ex_data [2];
    logic [4:0]  ex_rd;
    logic        ex_we, ex_re, ex_st;
    logic [4:0]  mem_rd;
    logic        mem_we, mem_re;
    logic [31:0] mem_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        lu_done, lu_kill, cnt_clr;
    logic [4:0]  lu_done_rd;

    logic [9:0]  id_rs_pk, ex_rs_pk;
    logic [63:0] ex_data_pk;
    logic [63:0] op_data;
    logic [3:0]  fwd_sel;
    logic        fwd_c, hold, lu_err;
    logic [31:0] busy;
    logic [2:0]  lu_cnt;
    logic [3:0]  sl_cnt, su_cnt;

    assign id_rs_pk   = {id_rs[1], id_rs[0]};
    assign ex_rs_pk   = {ex_rs[1], ex_rs[0]};
    assign ex_data_pk = {ex_data[1], ex_data[0]};

    always #5 clk = ~clk;

    ex_fwd_scoreboard #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_RD(NUM_RD), .LU_MAX(LU_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_rs_addr_i(id_rs_pk), .id_rs_used_i(id_used),
        .id_rd_addr_i(id_rd), .id_reg_w_ena_i(id_reg_w), .id_mem_w_ena_i(id_mem_w),
        .id_long_op_i(id_long), .flush_i(flush),
        .ex_rs_addr_i(ex_rs_pk), .ex_rs_data_i(ex_data_pk), .ex_rd_addr_i(ex_rd),
        .ex_reg_w_ena_i(ex_we), .ex_mem_r_ena_i(ex_re), .ex_mem_w_ena_i(ex_st),
        .mem_rd_addr_i(mem_rd), .mem_reg_w_ena_i(mem_we), .mem_mem_r_ena_i(mem_re),
        .mem_reg_w_data_i(mem_data),
        .wb_rd_addr_i(wb_rd), .wb_reg_w_ena_i(wb_we), .wb_reg_w_data_i(wb_data),
        .lu_done_i(lu_done), .lu_done_rd_i(lu_done_rd), .lu_kill_i(lu_kill), .cnt_clr_i(cnt_clr),
        .ex_op_data_o(op_data), .fwd_sel_o(fwd_sel), .fwd_c_o(fwd_c),
        .hazard_hold_o(hold), .busy_o(busy), .lu_cnt_o(lu_cnt), .lu_err_o(lu_err),
        .stall_load_cnt_o(sl_cnt), .stall_lu_cnt_o(su_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_reg_w = 0; id_mem_w = 0; id_long = 0; flush = 0;
        id_rs[0] = 0; id_rs[1] = 0; id_used = 0; id_rd = 0;
        ex_rs[0] = 0; ex_rs[1] = 0; ex_data[0] = 32'h1111; ex_data[1] = 32'h2222;
        ex_rd = 0; ex_we = 0; ex_re = 0; ex_st = 0;
        mem_rd = 0; mem_we = 0; mem_re = 0; mem_data = 32'hAAAA;
        wb_rd = 0; wb_we = 0; wb_data = 32'hBBBB;
        lu_done = 0; lu_done_rd = 0; lu_kill = 0; cnt_clr = 0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] b, input logic [2:0] c);
        chk({tag, "_busy"}, 64'(busy), 64'(b));
        chk({tag, "_lucnt"}, 64'(lu_cnt), 64'(c));
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy [32];
    int          m_cnt, m_sl, m_su;
    bit          m_err;
    logic        e_lu, e_hz, e_hold, e_fc;
    logic [3:0]  e_sel;
    logic [63:0] e_data;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_cnt = 0; m_sl = 0; m_su = 0; m_err = 0;
    endtask

    task automatic model_comb();
        bit raw, waw, st;
        int s;
        logic [31:0] d;
        e_lu = 0;
        if (ex_re && ex_we && ex_rd != 0)
            for (int k = 0; k < 2; k++)
                if (id_used[k] && id_rs[k] == ex_rd && !(k == 1 && id_mem_w)) e_lu = 1;
        raw = 0;
        for (int k = 0; k < 2; k++)
            if (id_used[k] && id_rs[k] != 0 && m_busy[id_rs[k]]) raw = 1;
        waw = id_reg_w && m_busy[id_rd];
        st  = id_long && (m_cnt == LU_MAX);
        e_hz   = raw || waw || st;
        e_hold = id_valid && !flush && (e_lu || e_hz);
        for (int k = 0; k < 2; k++) begin
            s = 0; d = ex_data[k];
            if (ex_rs[k] != 0) begin
                if (mem_we && !mem_re && mem_rd == ex_rs[k]) begin s = 2; d = mem_data; end
                else if (wb_we && wb_rd == ex_rs[k]) begin s = 1; d = wb_data; end
            end
            e_sel[2*k +: 2]   = 2'(s);
            e_data[32*k +: 32] = d;
        end
        e_fc = ex_st && mem_re && mem_we && mem_rd != 0 && mem_rd == ex_rs[1];
    endtask

    task automatic model_step();
        bit issue;
        issue = id_valid && id_long && !flush && !e_hold;
        if (lu_done && !m_busy[lu_done_rd]) m_err = 1;
        if (lu_kill) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_cnt = 0;
        end else begin
            if (lu_done && m_busy[lu_done_rd]) begin m_busy[lu_done_rd] = 0; m_cnt--; end
            if (issue) begin
                if (id_rd != 0) m_busy[id_rd] = 1;
                m_cnt++;
            end
        end
        if (cnt_clr) begin m_sl = 0; m_su = 0; end
        else begin
            if (e_hold && e_lu && m_sl < SAT) m_sl++;
            if (e_hold && e_hz && m_su < SAT) m_su++;
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [4:0] ex_rs0, ex_rs1, mem_rd;
        logic       mem_we, mem_re;
        logic [4:0] wb_rd;
        logic       wb_we, ex_st;
        logic [4:0] ex_rd;
        logic       ex_ld;
        logic [4:0] id_rs0, id_rs1;
        logic [1:0] id_used;
        logic       id_st;
        logic [3:0] exp_sel;
        logic       exp_fc, exp_hold;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    function automatic logic [31:0] opexp(input logic [1:0] s, input int k);
        if (s == 2'b10) return 32'hAAAA;
        if (s == 2'b01) return 32'hBBBB;
        return (k == 0) ? 32'h1111 : 32'h2222;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{ex_rs0:5, mem_rd:5, mem_we:1, wb_rd:5, wb_we:1, exp_sel:4'b0010, default:0};
        vt[1]  = '{ex_rs0:5, mem_rd:0, mem_we:1, wb_rd:5, wb_we:1, exp_sel:4'b0001, default:0};
        vt[2]  = '{ex_rs0:0, mem_rd:0, mem_we:1, wb_rd:0, wb_we:1, exp_sel:4'b0000, default:0};
        vt[3]  = '{ex_rs0:5, mem_rd:5, mem_we:1, mem_re:1, wb_rd:5, wb_we:1, exp_sel:4'b0001, default:0};
        vt[4]  = '{ex_rs0:6, ex_rs1:6, mem_rd:6, mem_we:1, exp_sel:4'b1010, default:0};
        vt[5]  = '{ex_rs0:3, ex_rs1:4, mem_rd:3, wb_rd:4, wb_we:1, exp_sel:4'b0100, default:0};
        vt[6]  = '{ex_st:1, mem_re:1, mem_we:1, mem_rd:8, ex_rs1:8, exp_fc:1, default:0};
        vt[7]  = '{ex_st:1, mem_re:1, mem_we:1, mem_rd:0, ex_rs1:0, default:0};
        vt[8]  = '{ex_rd:3, ex_ld:1, id_rs0:3, id_used:2'b01, exp_hold:1, default:0};
        vt[9]  = '{ex_rd:3, ex_ld:1, id_rs1:3, id_used:2'b10, id_st:1, default:0};
        vt[10] = '{ex_rd:3, ex_ld:1, id_rs1:3, id_used:2'b10, exp_hold:1, default:0};
        vt[11] = '{ex_rd:3, ex_ld:1, id_rs0:3, id_used:2'b01, id_st:1, exp_hold:1, default:0};
        vt[12] = '{ex_rd:0, ex_ld:1, id_rs0:0, id_used:2'b01, default:0};
        vt[13] = '{ex_rd:3, ex_ld:1, id_rs0:3, id_used:2'b00, default:0};
        vt[14] = '{ex_rs0:9, wb_rd:9, wb_we:0, default:0};

        idle();
        rst_n = 0;
        #12;
        chk_state("reset", 32'h0, 3'd0);
        chk("reset_err", 64'(lu_err), 64'd0);
        chk("reset_sl", 64'(sl_cnt), 64'd0);
        chk("reset_su", 64'(su_cnt), 64'd0);
        chk("reset_hold", 64'(hold), 64'd0);
        rst_n = 1;
        tick();

        for (int i = 0; i < NV; i++) begin
            idle();
            id_valid = 1; ex_we = 1;
            ex_rs[0] = vt[i].ex_rs0; ex_rs[1] = vt[i].ex_rs1;
            mem_rd = vt[i].mem_rd; mem_we = vt[i].mem_we; mem_re = vt[i].mem_re;
            wb_rd = vt[i].wb_rd; wb_we = vt[i].wb_we; ex_st = vt[i].ex_st;
            ex_rd = vt[i].ex_rd; ex_re = vt[i].ex_ld;
            id_rs[0] = vt[i].id_rs0; id_rs[1] = vt[i].id_rs1;
            id_used = vt[i].id_used; id_mem_w = vt[i].id_st;
            #1;
            chk($sformatf("vec%0d_sel", i), 64'(fwd_sel), 64'(vt[i].exp_sel));
            chk($sformatf("vec%0d_data", i), op_data,
                {opexp(vt[i].exp_sel[3:2], 1), opexp(vt[i].exp_sel[1:0], 0)});
            chk($sformatf("vec%0d_fwdc", i), 64'(fwd_c), 64'(vt[i].exp_fc));
            chk($sformatf("vec%0d_hold", i), 64'(hold), 64'(vt[i].exp_hold));
        end

        idle();
        rst_n = 0; #2; rst_n = 1;
        tick();

        // load-use: one-cycle bubble, then store-data case resolved by fwd_c
        idle(); id_valid = 1; id_rs[0] = 3; id_used = 2'b01; id_reg_w = 1; id_rd = 4;
        ex_rd = 3; ex_we = 1; ex_re = 1;
        #1 chk("lduse_hold", 64'(hold), 64'd1);
        tick();
        ex_we = 0; ex_re = 0;
        #1 chk("lduse_released", 64'(hold), 64'd0);
        chk("lduse_cnt", 64'(sl_cnt), 64'd1);
        chk("lduse_lucnt", 64'(su_cnt), 64'd0);
        tick();
        idle(); id_valid = 1; id_mem_w = 1; id_rs[0] = 1; id_rs[1] = 3; id_used = 2'b11;
        ex_rd = 3; ex_we = 1; ex_re = 1;
        #1 chk("store_nohold", 64'(hold), 64'd0);
        tick();
        idle(); ex_st = 1; ex_rs[0] = 1; ex_rs[1] = 3; mem_rd = 3; mem_we = 1; mem_re = 1;
        #1 chk("store_fwdc", 64'(fwd_c), 64'd1);
        chk("store_ldcnt", 64'(sl_cnt), 64'd1);
        tick();

        // scoreboard RAW held until the cycle after lu_done
        idle(); id_valid = 1; id_long = 1; id_reg_w = 1; id_rd = 7;
        #1 chk("div_issue_hold", 64'(hold), 64'd0);
        tick();
        chk_state("div_issued", 32'h80, 3'd1);
        idle(); id_valid = 1; id_rs[0] = 7; id_used = 2'b01; id_reg_w = 1; id_rd = 10;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("raw_hold%0d", c), 64'(hold), 64'd1);
            tick();
        end
        lu_done = 1; lu_done_rd = 7;
        #1 chk("raw_no_bypass", 64'(hold), 64'd1);
        tick();
        lu_done = 0;
        #1 chk("raw_released", 64'(hold), 64'd0);
        chk_state("div_done", 32'h0, 3'd0);
        chk("raw_stall_cnt", 64'(su_cnt), 64'd4);
        idle();
        tick();

        // structural, WAW, issue+done on the same rd
        idle(); id_valid = 1; id_long = 1; id_reg_w = 1; id_rd = 1;
        tick();
        id_rd = 2;
        tick();
        chk_state("two_out", 32'h6, 3'd2);
        id_rd = 3;
        #1 chk("struct_hold", 64'(hold), 64'd1);
        idle(); id_valid = 1; id_reg_w = 1; id_rd = 1;
        #1 chk("waw_hold", 64'(hold), 64'd1);
        idle(); lu_done = 1; lu_done_rd = 2;
        tick();
        chk_state("x2_done", 32'h2, 3'd1);
        idle(); id_valid = 1; id_long = 1; id_rd = 1; lu_done = 1; lu_done_rd = 1;
        #1 chk("same_rd_nohold", 64'(hold), 64'd0);
        tick();
        chk_state("same_rd", 32'h2, 3'd1);
        chk("no_err_yet", 64'(lu_err), 64'd0);

        // kill, error, async reset
        idle(); id_valid = 1; id_long = 1; id_reg_w = 1; id_rd = 4;
        tick();
        chk_state("pre_kill", 32'h12, 3'd2);
        idle(); lu_kill = 1; lu_done = 1; lu_done_rd = 1;
        tick();
        chk_state("kill", 32'h0, 3'd0);
        idle(); lu_kill = 1; id_valid = 1; id_long = 1; id_reg_w = 1; id_rd = 5;
        tick();
        chk_state("kill_over_issue", 32'h0, 3'd0);
        idle(); lu_done = 1; lu_done_rd = 9;
        tick();
        chk("err_set", 64'(lu_err), 64'd1);
        idle();
        tick();
        chk("err_sticky", 64'(lu_err), 64'd1);
        idle(); id_valid = 1; id_long = 1; id_reg_w = 1; id_rd = 7;
        tick();
        idle(); id_valid = 1; id_rs[0] = 7; id_used = 2'b01;
        #1 chk("pre_rst_hold", 64'(hold), 64'd1);
        tick();
        #1 rst_n = 0;
        #1;
        chk_state("midrst", 32'h0, 3'd0);
        chk("midrst_err", 64'(lu_err), 64'd0);
        chk("midrst_sl", 64'(sl_cnt), 64'd0);
        chk("midrst_su", 64'(su_cnt), 64'd0);
        chk("midrst_hold", 64'(hold), 64'd0);
        rst_n = 1;
        tick();

        // saturation and clear
        idle(); id_valid = 1; id_rs[0] = 3; id_used = 2'b01; ex_rd = 3; ex_we = 1; ex_re = 1;
        for (int c = 0; c < 20; c++) tick();
        chk("sat_load", 64'(sl_cnt), 64'(SAT));
        chk("sat_lu_zero", 64'(su_cnt), 64'd0);
        cnt_clr = 1;
        tick();
        chk("clr_wins", 64'(sl_cnt), 64'd0);
        cnt_clr = 0;
        tick();
        chk("after_clr", 64'(sl_cnt), 64'd1);

        // randomized traffic against the model
        idle();
        rst_n = 0; #2; rst_n = 1;
        model_reset();
        tick();
        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs[0] = 5'($urandom_range(0, 7));
            id_rs[1] = 5'($urandom_range(0, 7));
            id_used  = 2'($urandom_range(0, 3));
            id_rd    = 5'($urandom_range(0, 7));
            id_reg_w = ($urandom_range(0, 1) != 0);
            id_mem_w = ($urandom_range(0, 3) == 0);
            id_long  = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            ex_rs[0] = 5'($urandom_range(0, 7));
            ex_rs[1] = 5'($urandom_range(0, 7));
            ex_data[0] = $urandom; ex_data[1] = $urandom;
            ex_rd = 5'($urandom_range(0, 7));
            ex_we = ($urandom_range(0, 1) != 0);
            ex_re = ($urandom_range(0, 1) != 0);
            ex_st = ($urandom_range(0, 1) != 0);
            mem_rd = 5'($urandom_range(0, 7));
            mem_we = ($urandom_range(0, 1) != 0);
            mem_re = ($urandom_range(0, 1) != 0);
            mem_data = $urandom;
            wb_rd = 5'($urandom_range(0, 7));
            wb_we = ($urandom_range(0, 1) != 0);
            wb_data = $urandom;
            lu_done    = ($urandom_range(0, 3) == 0);
            lu_done_rd = 5'($urandom_range(0, 7));
            lu_kill    = ($urandom_range(0, 31) == 0);
            cnt_clr    = ($urandom_range(0, 63) == 0);
            #1;
            model_comb();
            chk($sformatf("rnd%0d_sel", n), 64'(fwd_sel), 64'(e_sel));
            chk($sformatf("rnd%0d_data", n), op_data, e_data);
            chk($sformatf("rnd%0d_fwdc", n), 64'(fwd_c), 64'(e_fc));
            chk($sformatf("rnd%0d_hold", n), 64'(hold), 64'(e_hold));
            model_step();
            tick();
            chk($sformatf("rnd%0d_busy", n), 64'(busy), 64'(model_busy()));
            chk($sformatf("rnd%0d_lucnt", n), 64'(lu_cnt), 64'(m_cnt));
            chk($sformatf("rnd%0d_err", n), 64'(lu_err), 64'(m_err));
            chk($sformatf("rnd%0d_sl", n), 64'(sl_cnt), 64'(m_sl));
            chk($sformatf("rnd%0d_su", n), 64'(su_cnt), 64'(m_su));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
